// File: rtl/t07_fpu_pkg.sv
// Shared team-07 FPU definitions: divider opcodes, post-stage state encoding
// and the writeback result record.
package t07_fpu_pkg;

  localparam logic [4:0] OP_DIV = 5'd7;
  localparam logic [4:0] OP_REM = 5'd8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FIX,
    HOLD
  } divpost_state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        dz;
    logic        err;
  } divpost_result_t;

endpackage

// File: rtl/t07_fpu_div_post_if.sv
// Bundle of issue, divider-result and writeback signals around the divider
// post stage; master is the surrounding pipeline, slave is the post stage.
interface t07_fpu_div_post_if;

  logic        start;
  logic [4:0]  op;
  logic [4:0]  rd;
  logic [31:0] dividend;
  logic        sign_a;
  logic        divisor_zero;

  logic        div_busy;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic        div_sign;

  logic        wb_ready;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        dz;
  logic        err;
  logic        stall;

  modport master (
    output start, op, rd, dividend, sign_a, divisor_zero,
    output div_busy, div_quotient, div_remainder, div_sign,
    output wb_ready,
    input  wb_valid, wb_data, wb_rd, dz, err, stall
  );

  modport slave (
    input  start, op, rd, dividend, sign_a, divisor_zero,
    input  div_busy, div_quotient, div_remainder, div_sign,
    input  wb_ready,
    output wb_valid, wb_data, wb_rd, dz, err, stall
  );

endinterface

// File: rtl/t07_fpu_sign_fix.sv
// Conditional two's-complement: passes the operand through, or negates it
// modulo 2^32 when neg_i is set (0 stays 0, 0x8000_0000 stays 0x8000_0000).
module t07_fpu_sign_fix (
  input  logic [31:0] val_i,
  input  logic        neg_i,
  output logic [31:0] res_o
);

  assign res_o = neg_i ? (~val_i + 32'd1) : val_i;

endmodule

// File: rtl/t07_fpu_div_post.sv
// Divider post-processing/writeback stage: waits for the divider handshake,
// applies sign and divide-by-zero fix-up, holds the result until accepted.
// Optional WAIT timeout is built when T07_FPU_DIVPOST_TIMEOUT_EN is defined.
module t07_fpu_div_post
  import t07_fpu_pkg::*;
#(
  parameter int TIMEOUT_W = 6
) (
  input logic                clk,
  input logic                nrst,
  t07_fpu_div_post_if.slave  bus
);

  if (TIMEOUT_W < 2) begin : g_param_check
    $error("TIMEOUT_W must be at least 2");
  end

  divpost_state_t  state_q;
  logic            armed_q;
  logic            is_rem_q;
  logic [4:0]      rd_q;
  logic [31:0]     dividend_q;
  logic            sign_a_q;
  logic            dzin_q;
  logic [31:0]     quot_q;
  logic [31:0]     rem_q;
  logic            dsign_q;
  logic            timeout_q;
  logic            valid_q;
  logic            stall_q;
  divpost_result_t res_q;
  divpost_result_t res_d;

  logic        issue;
  logic        done;
  logic        expire;
  logic [31:0] fix_operand;
  logic        fix_negate;
  logic [31:0] fix_result;

  assign issue = (state_q == IDLE) && bus.start &&
                 ((bus.op == OP_DIV) || (bus.op == OP_REM));
  // A low busy only counts once the divider has been seen busy at least once.
  assign done  = (state_q == WAIT) && armed_q && !bus.div_busy;

`ifdef T07_FPU_DIVPOST_TIMEOUT_EN
  // Last count before the counter would reach 2^TIMEOUT_W - 1.
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  logic [TIMEOUT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else if (issue) begin
      cnt_q <= '0;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire = (state_q == WAIT) && !done && (cnt_q == CNT_LAST);
`else
  assign expire = 1'b0;
`endif

  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    fix_operand = quot_q;
    fix_negate  = dsign_q;
    if (dzin_q) begin
      fix_operand = is_rem_q ? dividend_q : 32'hFFFF_FFFF;
      fix_negate  = is_rem_q & sign_a_q;
    end else if (is_rem_q) begin
      fix_operand = rem_q;
      fix_negate  = sign_a_q;
    end
  end

  t07_fpu_sign_fix u_sign_fix (
    .val_i (fix_operand),
    .neg_i (fix_negate),
    .res_o (fix_result)
  );

  always_comb begin
    res_d.data = fix_result;
    res_d.rd   = rd_q;
    res_d.dz   = dzin_q;
    res_d.err  = 1'b0;
    if (timeout_q) begin
      res_d.data = '0;
      res_d.dz   = 1'b0;
      res_d.err  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the values present before the clock edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      is_rem_q   <= 1'b0;
      rd_q       <= '0;
      dividend_q <= '0;
      sign_a_q   <= 1'b0;
      dzin_q     <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      dsign_q    <= 1'b0;
      timeout_q  <= 1'b0;
      valid_q    <= 1'b0;
      stall_q    <= 1'b0;
      res_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (issue) begin
            is_rem_q   <= (bus.op == OP_REM);
            rd_q       <= bus.rd;
            dividend_q <= bus.dividend;
            sign_a_q   <= bus.sign_a;
            dzin_q     <= bus.divisor_zero;
            armed_q    <= 1'b0;
            timeout_q  <= 1'b0;
            stall_q    <= 1'b1;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (bus.div_busy) begin
            armed_q <= 1'b1;
          end
          if (done) begin
            quot_q  <= bus.div_quotient;
            rem_q   <= bus.div_remainder;
            dsign_q <= bus.div_sign;
            state_q <= FIX;
          end else if (expire) begin
            timeout_q <= 1'b1;
            state_q   <= FIX;
          end
        end
        FIX: begin
          res_q   <= res_d;
          valid_q <= 1'b1;
          state_q <= HOLD;
        end
        HOLD: begin
          if (bus.wb_ready) begin
            valid_q <= 1'b0;
            stall_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.wb_valid = valid_q;
  assign bus.wb_data  = res_q.data;
  assign bus.wb_rd    = res_q.rd;
  assign bus.dz       = res_q.dz;
  assign bus.err      = res_q.err;
  assign bus.stall    = stall_q;

endmodule

// File: tb/tb_t07_fpu_div_post.sv
// Scoreboard bench for t07_fpu_div_post: directed issues push expected
// writebacks; a negedge monitor pops and compares each presented result.
module tb_t07_fpu_div_post;
  import t07_fpu_pkg::*;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  t07_fpu_div_post_if bus ();

  t07_fpu_div_post #(.TIMEOUT_W(6)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  divpost_result_t exp_q[$];
  divpost_result_t mon_e;
  logic presented = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares once per presented writeback, at the falling edge.
  always @(negedge clk) begin
    if (nrst && bus.wb_valid && !presented) begin
      presented = 1'b1;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_wb: got rd %0d data %h, expected no writeback", bus.wb_rd, bus.wb_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wb_data", bus.wb_data, mon_e.data);
        check("wb_rd", 32'(bus.wb_rd), 32'(mon_e.rd));
        check("wb_dz", 32'(bus.dz), 32'(mon_e.dz));
        check("wb_err", 32'(bus.err), 32'(mon_e.err));
      end
    end
    if (!bus.wb_valid) presented = 1'b0;
  end

  task automatic expect_wb(input logic [31:0] data, input logic [4:0] rd, input logic dz, input logic err);
    divpost_result_t e;
    e.data = data;
    e.rd   = rd;
    e.dz   = dz;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [4:0] op, input logic [4:0] rd, input logic [31:0] a,
                       input logic sa, input logic dzero);
    bus.start = 1'b1; bus.op = op; bus.rd = rd;
    bus.dividend = a; bus.sign_a = sa; bus.divisor_zero = dzero;
    tick();
    bus.start = 1'b0; bus.op = '0; bus.rd = '0;
    bus.dividend = '0; bus.sign_a = 1'b0; bus.divisor_zero = 1'b0;
    check("stall_after_issue", 32'(bus.stall), 32'd1);
  endtask

  // Drives the divider handshake; checks FIX at D+1 and valid at D+2.
  task automatic divide(input int pre_low, input int high, input logic [31:0] q,
                        input logic [31:0] r, input logic s);
    bus.div_busy = 1'b0;
    repeat (pre_low) tick();
    if (pre_low > 0) check("no_complete_before_armed", 32'(bus.wb_valid), 32'd0);
    bus.div_busy = 1'b1;
    repeat (high) tick();
    bus.div_busy = 1'b0;
    bus.div_quotient = q; bus.div_remainder = r; bus.div_sign = s;
    tick();
    bus.div_quotient = 32'hDEAD_BEEF; bus.div_remainder = 32'hDEAD_BEEF; bus.div_sign = ~s;
    check("valid_in_fix", 32'(bus.wb_valid), 32'd0);
    tick();
    check("valid_at_d2", 32'(bus.wb_valid), 32'd1);
  endtask

  task automatic release_wb(input int hold, input logic [31:0] data, input logic poke_start);
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 32'(bus.wb_valid), 32'd1);
      check("hold_data", bus.wb_data, data);
      check("hold_stall", 32'(bus.stall), 32'd1);
      bus.start = poke_start && (i == 1);
      bus.op = OP_DIV;
      tick();
    end
    bus.start = 1'b0; bus.op = '0;
    bus.wb_ready = 1'b1;
    tick();
    bus.wb_ready = 1'b0;
    check("idle_valid", 32'(bus.wb_valid), 32'd0);
    check("idle_stall", 32'(bus.stall), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.op = '0; bus.rd = '0; bus.dividend = '0;
    bus.sign_a = 1'b0; bus.divisor_zero = 1'b0; bus.div_busy = 1'b0;
    bus.div_quotient = '0; bus.div_remainder = '0; bus.div_sign = 1'b0;
    bus.wb_ready = 1'b0;
    nrst = 1'b0;
    repeat (2) tick();
    check("rst_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_data", bus.wb_data, 32'd0);
    check("rst_rd", 32'(bus.wb_rd), 32'd0);
    check("rst_dz", 32'(bus.dz), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    nrst = 1'b1;
    tick();

    // -51 / 7: quotient -7
    expect_wb(32'hFFFF_FFF9, 5'd3, 1'b0, 1'b0);
    issue(OP_DIV, 5'd3, 32'd51, 1'b1, 1'b0);
    divide(0, 3, 32'd7, 32'd2, 1'b1);
    release_wb(0, 32'hFFFF_FFF9, 1'b0);

    // -51 % 7: remainder -2
    expect_wb(32'hFFFF_FFFE, 5'd4, 1'b0, 1'b0);
    issue(OP_REM, 5'd4, 32'd51, 1'b1, 1'b0);
    divide(0, 3, 32'd7, 32'd2, 1'b1);
    release_wb(0, 32'hFFFF_FFFE, 1'b0);

    // Divide by zero, held 4 cycles with a stray start during HOLD
    expect_wb(32'hFFFF_FFFF, 5'd5, 1'b1, 1'b0);
    issue(OP_DIV, 5'd5, 32'd9, 1'b0, 1'b1);
    divide(0, 1, 32'd0, 32'd0, 1'b0);
    release_wb(4, 32'hFFFF_FFFF, 1'b1);

    // Remainder by zero returns the dividend
    expect_wb(32'd5, 5'd6, 1'b1, 1'b0);
    issue(OP_REM, 5'd6, 32'd5, 1'b0, 1'b1);
    divide(0, 2, 32'd0, 32'd0, 1'b0);
    release_wb(0, 32'd5, 1'b0);

    // Low busy at WAIT entry must not complete
    expect_wb(32'd12, 5'd7, 1'b0, 1'b0);
    issue(OP_DIV, 5'd7, 32'd36, 1'b0, 1'b0);
    divide(2, 2, 32'd12, 32'd0, 1'b0);
    release_wb(0, 32'd12, 1'b0);

    // Zero quotient with negative sign stays zero
    expect_wb(32'd0, 5'd8, 1'b0, 1'b0);
    issue(OP_DIV, 5'd8, 32'd3, 1'b1, 1'b0);
    divide(0, 2, 32'd0, 32'd3, 1'b1);
    release_wb(0, 32'd0, 1'b0);

    // 0x8000_0000 / -1 overflow
    expect_wb(32'h8000_0000, 5'd9, 1'b0, 1'b0);
    issue(OP_DIV, 5'd9, 32'h8000_0000, 1'b1, 1'b0);
    divide(0, 2, 32'h8000_0000, 32'd0, 1'b1);
    release_wb(0, 32'h8000_0000, 1'b0);

    // Negative dividend, remainder by zero: -5
    expect_wb(32'hFFFF_FFFB, 5'd10, 1'b1, 1'b0);
    issue(OP_REM, 5'd10, 32'd5, 1'b1, 1'b1);
    divide(0, 1, 32'd0, 32'd0, 1'b0);
    release_wb(0, 32'hFFFF_FFFB, 1'b0);

    // wb_ready held high through WAIT/FIX has no effect before HOLD
    expect_wb(32'd100, 5'd11, 1'b0, 1'b0);
    bus.wb_ready = 1'b1;
    issue(OP_DIV, 5'd11, 32'd300, 1'b0, 1'b0);
    divide(0, 2, 32'd100, 32'd0, 1'b0);
    tick();
    bus.wb_ready = 1'b0;
    check("ready_early_idle_valid", 32'(bus.wb_valid), 32'd0);
    check("ready_early_idle_stall", 32'(bus.stall), 32'd0);

    // Unsupported opcode does not start
    bus.start = 1'b1; bus.op = 5'd3;
    tick();
    bus.start = 1'b0; bus.op = '0;
    check("bad_op_stall", 32'(bus.stall), 32'd0);
    tick();

    // Reset mid-WAIT clears everything immediately
    issue(OP_DIV, 5'd12, 32'd8, 1'b0, 1'b0);
    bus.div_busy = 1'b1;
    tick();
    nrst = 1'b0;
    #1;
    check("midrst_valid", 32'(bus.wb_valid), 32'd0);
    check("midrst_data", bus.wb_data, 32'd0);
    check("midrst_rd", 32'(bus.wb_rd), 32'd0);
    check("midrst_stall", 32'(bus.stall), 32'd0);
    bus.div_busy = 1'b0;
    tick();
    nrst = 1'b1;
    tick();

    // Recovery after reset
    expect_wb(32'd33, 5'd13, 1'b0, 1'b0);
    issue(OP_REM, 5'd13, 32'd133, 1'b0, 1'b0);
    divide(0, 1, 32'd1, 32'd33, 1'b1);
    release_wb(0, 32'd33, 1'b0);

`ifdef T07_FPU_DIVPOST_TIMEOUT_EN
    // Divider never busy: 63 WAIT cycles, FIX, then err result
    begin
      int n;
      expect_wb(32'd0, 5'd14, 1'b0, 1'b1);
      issue(OP_DIV, 5'd14, 32'd5, 1'b0, 1'b1);
      bus.div_busy = 1'b0;
      n = 0;
      while (!bus.wb_valid && n < 80) begin
        tick();
        n++;
      end
      check("timeout_latency", 32'(n), 32'd64);
      release_wb(0, 32'd0, 1'b0);
    end
`endif

    repeat (2) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/t07_fpu_div_post.md
# t07_fpu_div_post

Post-processing and writeback stage sitting directly downstream of the team-07 FPU integer divider. It latches the issued division (op, destination, dividend) and waits for the divider's `busy` handshake to complete. It then applies sign correction and divide-by-zero semantics, and holds the result on a valid/ready writeback port until the register-file arbiter accepts it. It also drives `stall` back to the issue logic while a division is in flight.

## Interface
Parameters:
- `TIMEOUT_W`, default 6: width of the WAIT timeout counter. Timeout fires at 2^TIMEOUT_W − 1 cycles.

Ports:
- `clk` in 1: clock.
- `nrst` in 1: reset, asynchronous, active-low.
- `start` in 1: issue pulse. Accepted only in IDLE.
- `op` in 5: operation at issue. `OP_DIV` = 5'd7 (quotient), `OP_REM` = 5'd8 (remainder). Any other value is ignored (no start).
- `rd` in 5: destination register at issue.
- `dividend` in 32: dividend magnitude at issue.
- `sign_a` in 1: dividend sign at issue.
- `divisor_zero` in 1: divisor magnitude is zero, sampled at issue.
- `div_busy` in 1: divider busy.
- `div_quotient` in 32: unsigned quotient magnitude.
- `div_remainder` in 32: unsigned remainder magnitude.
- `div_sign` in 1: quotient sign from the divider.
- `wb_ready` in 1: writeback accepted.
- `wb_valid` out 1: writeback data valid.
- `wb_data` out 32: signed result.
- `wb_rd` out 5: destination register.
- `dz` out 1: result came from a divide-by-zero. Valid with `wb_valid`.
- `err` out 1: timeout result. Valid with `wb_valid`.
- `stall` out 1: high in every state except IDLE.

## Operation
- States: IDLE → WAIT → FIX → HOLD → IDLE.
- **IDLE:** when `start` is high and `op` is `OP_DIV` or `OP_REM`, the block:
  - captures `op`, `rd`, `dividend`, `sign_a` and `divisor_zero`;
  - clears the `armed` flag and the timeout counter;
  - moves to WAIT.
- **WAIT:**
  - `armed` sets on the first sampled `div_busy` = 1.
  - Once `armed` is set, a sampled `div_busy` = 0 captures `div_quotient`, `div_remainder` and `div_sign`, then moves to FIX.
  - A low `div_busy` before `armed` is set is ignored. This covers the divider's load-cycle skew.
- **FIX:** computes the result into the `wb_data` register.
  - **divisor_zero, `OP_DIV`:** 32'hFFFF_FFFF, with `dz` = 1.
  - **divisor_zero, `OP_REM`:** `sign_a` ? −dividend : dividend, with `dz` = 1.
  - **`OP_DIV`:** `div_sign` ? two's-complement negation of the quotient : quotient. A quotient of 0 is never negated to a nonzero value.
  - **`OP_REM`:** the remainder takes the dividend's sign, so `sign_a` ? −remainder : remainder.
  - **Overflow:** 0x8000_0000 ÷ −1 yields magnitude 0x8000_0000. Negation leaves it 0x8000_0000 with no flag.
  - All arithmetic is 32-bit modulo. Upper bits are discarded.
  - FIX then moves to HOLD.
- **HOLD:** `wb_valid` = 1, and `wb_data`, `wb_rd`, `dz` and `err` stay stable. `wb_ready` = 1 returns the block to IDLE.
- `start` outside IDLE is ignored. Issue logic must respect `stall`.
- Reset mid-operation: the block returns to IDLE immediately. All captured state is discarded.

## Timing
- Reset values: `wb_valid` = 0, `wb_data` = 0, `wb_rd` = 0, `dz` = 0, `err` = 0, `stall` = 0, state = IDLE.
- Issue edge at cycle N puts the block in WAIT during N+1, so `stall` = 1 from N+1.
- Let cycle D be the WAIT cycle in which armed `div_busy` = 0 is sampled. Then:
  - FIX occupies D+1;
  - `wb_valid` = 1 from D+2.
- `wb_ready` high during HOLD cycle H puts the block in IDLE in H+1, with `wb_valid` = 0 and `stall` = 0.
- `wb_ready` asserted outside HOLD has no effect.
- Minimum issue-to-issue spacing is 5 cycles.

## Configuration
- **`T07_FPU_DIVPOST_TIMEOUT_EN` defined:** the WAIT counter increments every WAIT cycle. When it reaches 2^TIMEOUT_W − 1 without completion, the block goes to FIX with `err` = 1 and `wb_data` = 0, and `dz` is forced to 0.
- **Undefined:** no counter is built and `err` is tied to 0. WAIT lasts indefinitely.

## Structure
- Shared package `t07_fpu_pkg` holds:
  - the `OP_DIV` and `OP_REM` localparams;
  - the state enum `divpost_state_t` (IDLE, WAIT, FIX, HOLD);
  - the result struct `{data, rd, dz, err}`.
- Sub-module `t07_fpu_sign_fix` is the combinational conditional two's-complement (32-bit in, negate flag, 32-bit out). FIX instantiates it once, with the operand muxed.

## Test plan
- Issue `OP_DIV` with `sign_a`=1, divider busy for 3 cycles then returning quotient 7, remainder 2, `div_sign`=1 → `wb_data`=0xFFFF_FFF9 two cycles after the busy-low sample, `dz`=0.
- Same result magnitudes with `OP_REM`, `sign_a`=1 → `wb_data`=0xFFFF_FFFE.
- `OP_DIV` with `divisor_zero`=1 → `wb_data`=0xFFFF_FFFF, `dz`=1. `OP_REM`, dividend 5, `sign_a`=0 → `wb_data`=5, `dz`=1.
- Hold `wb_ready`=0 for 4 cycles in HOLD → `wb_valid` and `wb_data` stable and `stall`=1. `wb_ready`=1 → IDLE next cycle. A `start` pulsed during HOLD is ignored.
- `div_busy` low at WAIT entry, then high 2 cycles, then low → completion only after the high phase (armed check).
- With the macro defined, `div_busy` is never asserted → after 63 WAIT cycles `wb_valid`=1, `err`=1, `wb_data`=0. Assert `nrst` mid-WAIT in a separate run → all outputs 0 immediately.
